bin_down_counter: RTL

- Synchronous binary down counter: the counting-direction complement of the team's up counter.
- Adds parallel load, count enable and a terminal-count flag, and feeds timeout/reload use in the counter education set.
- Built from internal single-bit flip-flop cells. The cell type is chosen by a parameter, so all four realizations can be compared in simulation.
- Every realization produces an identical q sequence.

---
 rtl/bin_down_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bin_down_counter.sv
// bin_down_counter: synchronous binary down counter with parallel load,
// count enable, combinational zero flag and registered borrow pulse.
// Each bit is a single flip-flop cell whose type (d/t/jk/rs) is chosen
// by the Realization parameter. The excitation decode is derived from
// (q, next), so every realization steps through the same q sequence.

// One-bit storage cell with asynchronous active-low clear.
// KIND: 0 = d-type, 1 = t-type, 2 = jk-type, 3 = rs-type.
// exc_a carries d / t / j / s and exc_b carries k / r (unused for d, t).
module bdc_cell #(
  parameter int KIND = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic exc_a,
  input  logic exc_b,
  output logic q
);
  logic q_d, q_q;

  // Characteristic equation of the selected flip-flop type.
  always_comb begin
    q_d = q_q;
    case (KIND)
      0: q_d = exc_a;
      2: begin
        case ({exc_a, exc_b})
          2'b10:   q_d = 1'b1;
          2'b01:   q_d = 1'b0;
          2'b11:   q_d = ~q_q;
          default: q_d = q_q;
        endcase
      end
      3: begin
        // r=s=1 is forbidden; the decode never produces it, so hold.
        case ({exc_a, exc_b})
          2'b10:   q_d = 1'b1;
          2'b01:   q_d = 1'b0;
          default: q_d = q_q;
        endcase
      end
      default: q_d = q_q ^ exc_a;
    endcase
  end

  // State bit; cleared immediately by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q_q <= 1'b0;
    else          q_q <= q_d;
  end

  assign q = q_q;
endmodule

module bin_down_counter #(
  parameter string Realization = "d-type",
  parameter int    DIGITS      = 3,
  parameter bit    WRAP        = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              load,
  input  logic [DIGITS-1:0] load_value,
  output logic [DIGITS-1:0] q,
  output logic              zero,
  output logic              borrow
);
  // Unknown realization strings fall back to t-type.
  localparam int KIND = (Realization == "d-type")  ? 0 :
                        (Realization == "jk-type") ? 2 :
                        (Realization == "rs-type") ? 3 : 1;

  localparam logic [DIGITS-1:0] ALL_ONES = {DIGITS{1'b1}};

  logic [DIGITS-1:0] q_next;
  logic [DIGITS-1:0] exc_a, exc_b;
  logic              borrow_d, borrow_q;

  // Next count: load beats enable; decrement from 0 wraps or saturates
  // and raises borrow either way.
  always_comb begin
    q_next   = q;
    borrow_d = 1'b0;
    if (load) begin
      q_next = load_value;
    end else if (enable) begin
      if (q != '0) begin
        q_next = q - DIGITS'(1);
      end else begin
        borrow_d = 1'b1;
        q_next   = WRAP ? ALL_ONES : '0;
      end
    end
  end

  // Excitation decode from (q, q_next). jk and rs share the same
  // set/clear pattern: j/s on a 0->1 bit, k/r on a 1->0 bit, both low
  // on a held bit. The jk toggle code is never issued, and r=s=1 cannot
  // occur because a bit cannot both rise and fall.
  always_comb begin
    exc_a = '0;
    exc_b = '0;
    case (KIND)
      0:       exc_a = q_next;
      1:       exc_a = q ^ q_next;
      default: begin
        exc_a = ~q & q_next;
        exc_b = q & ~q_next;
      end
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bdc_cell #(.KIND(KIND)) u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .exc_a   (exc_a[i]),
      .exc_b   (exc_b[i]),
      .q       (q[i])
    );
  end

  // Borrow pulse register, one cycle after an attempted decrement at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) borrow_q <= 1'b0;
    else          borrow_q <= borrow_d;
  end

  assign borrow = borrow_q;
  assign zero   = (q == '0);
endmodule
